// File: rtl/led_seq_pkg.sv
// Shared types and constants for the status-LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam int NUM_LEDS = 5;

    localparam logic [NUM_LEDS-1:0] ENTRY_COUNT  = 5'b00000;
    localparam logic [NUM_LEDS-1:0] ENTRY_CHASE  = 5'b00001;
    localparam logic [NUM_LEDS-1:0] ENTRY_BOUNCE = 5'b00001;
    localparam logic [NUM_LEDS-1:0] ENTRY_BLINK  = 5'b11111;

    // Ends of the bounce travel; the lit LED reverses direction here.
    localparam logic [NUM_LEDS-1:0] BOUNCE_TOP    = 5'b10000;
    localparam logic [NUM_LEDS-1:0] BOUNCE_BOTTOM = 5'b00001;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_COUNT:  return MODE_CHASE;
            MODE_CHASE:  return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_BLINK;
            default:     return MODE_COUNT;
        endcase
    endfunction

    function automatic logic [NUM_LEDS-1:0] entry_pattern(input mode_t m);
        case (m)
            MODE_COUNT:  return ENTRY_COUNT;
            MODE_CHASE:  return ENTRY_CHASE;
            MODE_BOUNCE: return ENTRY_BOUNCE;
            default:     return ENTRY_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_btn_debounce.sv
// Push-button conditioning: two-flop synchroniser, stable-time debounce
// and a single-cycle pulse on each accepted press (release is silent).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic CLK_IN,
    input  logic RST_N,
    input  logic BTN_IN,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= BTN_IN;
            sync      <= sync_meta;
        end
    end

    // Accept a new level only after it has differed from db for the full window.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (sync == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db  <= sync;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of db for rising-edge detection.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) db_q <= 1'b0;
        else        db_q <= db;
    end

    assign press = db & ~db_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Status-LED pattern engine: button-selected mode, prescaled step tick,
// registered LED pattern driven straight to the pins.
//
//   state        | meaning
//   MODE_COUNT   | binary count 0..31 on the LEDs
//   MODE_CHASE   | single lit LED rotating left
//   MODE_BOUNCE  | single lit LED travelling end to end and back
//   MODE_BLINK   | all LEDs toggling together
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int STEP_DIV        = 1500000,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       BTN_IN,
    output logic       GLED5,
    output logic       RLED1,
    output logic       RLED2,
    output logic       RLED3,
    output logic       RLED4,
    output logic [1:0] MODE_OUT
);

    localparam int PW = $clog2(STEP_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

    logic                press;
    logic [PW-1:0]       presc;
    logic                step_tick;
    mode_t               mode;
    logic [NUM_LEDS-1:0] led;
    logic                dir_up;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .BTN_IN (BTN_IN),
        .press  (press)
    );

    assign step_tick = (presc == PRE_LAST);

    // Step prescaler; a press restarts the step period so the entry pattern
    // is always shown for a full step.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N)                  presc <= '0;
        else if (press || step_tick) presc <= '0;
        else                         presc <= presc + 1'b1;
    end

    // Mode FSM and pattern register; a press takes priority over a coincident tick.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            mode   <= MODE_COUNT;
            led    <= '0;
            dir_up <= 1'b1;
        end else if (press) begin
            mode   <= next_mode(mode);
            led    <= entry_pattern(next_mode(mode));
            dir_up <= 1'b1;
        end else if (step_tick) begin
            case (mode)
                MODE_COUNT: led <= led + 1'b1;
                MODE_CHASE: led <= {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
                MODE_BOUNCE: begin
                    if (dir_up) begin
                        if (led == BOUNCE_TOP) begin
                            dir_up <= 1'b0;
                            led    <= BOUNCE_TOP >> 1;
                        end else begin
                            led <= led << 1;
                        end
                    end else begin
                        if (led == BOUNCE_BOTTOM) begin
                            dir_up <= 1'b1;
                            led    <= BOUNCE_BOTTOM << 1;
                        end else begin
                            led <= led >> 1;
                        end
                    end
                end
                default: led <= ~led;
            endcase
        end
    end

    assign RLED1    = led[0];
    assign RLED2    = led[1];
    assign RLED3    = led[2];
    assign RLED4    = led[3];
    assign GLED5    = led[4];
    assign MODE_OUT = mode;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: stimulus pushes expected {cycle, mode, led} entries,
// the monitor pops one on every observed output change and compares.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       gled5, rled1, rled2, rled3, rled4;
    logic [1:0] mode_out;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic [4:0] led;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   base   = 0;
    int   req    = 0;
    bit   mon_en = 1'b0;
    bit   done   = 1'b0;
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    led_pattern_sequencer #(
        .STEP_DIV        (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLK_IN   (clk),
        .RST_N    (rst_n),
        .BTN_IN   (btn),
        .GLED5    (gled5),
        .RLED1    (rled1),
        .RLED2    (rled2),
        .RLED3    (rled3),
        .RLED4    (rled4),
        .MODE_OUT (mode_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int t, input logic [1:0] m, input logic [4:0] l, input string tag);
        exp_t e;
        e.cyc  = base + t;
        e.mode = m;
        e.led  = l;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    // Return at the falling edge that follows rising edge number t after base.
    task automatic at_neg_after(input int t);
        @(negedge clk);
        while (cyc < base + t) @(negedge clk);
    endtask

    // Monitor: compares on each output change, or on demand from the stimulus.
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        int         seen;
        exp_t       e;
        prev = '0;
        seen = 0;
        forever begin
            @(negedge clk or sample_ev);
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL queue_drained: %0d entries left, required 0", exp_q.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
            if (mon_en) begin
                cur = {mode_out, gled5, rled4, rled3, rled2, rled1};
                if (cur !== prev || req != seen) begin
                    seen = req;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: mode=%0d led=%b at cyc %0d, no change expected",
                                 cur[6:5], cur[4:0], cyc - base);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== {e.mode, e.led} || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL %s: got mode=%0d led=%b at cyc %0d, required mode=%0d led=%b at cyc %0d",
                                     e.tag, cur[6:5], cur[4:0], cyc - base, e.mode, e.led, e.cyc - base);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Stimulus; times are rising-edge counts since the latest reset release.
    initial begin
        rst_n = 1'b1;
        btn   = 1'b0;
        #1 rst_n = 1'b0;
        #1 mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;

        // Reset behaviour: count visible, then async clear between edges.
        push(4, 2'd0, 5'd1, "rst_count_1");
        push(8, 2'd0, 5'd2, "rst_count_2");
        push(8, 2'd0, 5'd0, "rst_async_clear");
        at_neg_after(8);
        #2 rst_n = 1'b0;
        #1 req++;
        ->sample_ev;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;

        // COUNT wrap over 32 ticks, then four more while the glitch is ignored.
        for (int i = 1; i <= 36; i++) push(4 * i, 2'd0, 5'(i), "count_step");
        at_neg_after(128);
        btn = 1'b1;
        at_neg_after(131);
        btn = 1'b0;

        // Held press into CHASE, then ticks while still held.
        push(147, 2'd1, 5'b00001, "press_to_chase");
        push(151, 2'd1, 5'b00010, "chase_1");
        push(155, 2'd1, 5'b00100, "chase_2");
        push(159, 2'd1, 5'b01000, "chase_3");
        push(163, 2'd1, 5'b10000, "chase_4");
        push(167, 2'd1, 5'b00001, "chase_5");
        push(171, 2'd1, 5'b00010, "chase_6");
        push(175, 2'd1, 5'b00100, "chase_7");
        push(179, 2'd1, 5'b01000, "chase_8");
        push(183, 2'd1, 5'b10000, "chase_9");
        push(187, 2'd1, 5'b00001, "chase_10");
        at_neg_after(140);
        btn = 1'b1;
        at_neg_after(170);
        btn = 1'b0;

        // Re-press into BOUNCE and a full bounce period plus one.
        push(188, 2'd2, 5'b00001, "press_to_bounce");
        push(192, 2'd2, 5'b00010, "bounce_1");
        push(196, 2'd2, 5'b00100, "bounce_2");
        push(200, 2'd2, 5'b01000, "bounce_3");
        push(204, 2'd2, 5'b10000, "bounce_4");
        push(208, 2'd2, 5'b01000, "bounce_5");
        push(212, 2'd2, 5'b00100, "bounce_6");
        push(216, 2'd2, 5'b00010, "bounce_7");
        push(220, 2'd2, 5'b00001, "bounce_8");
        push(224, 2'd2, 5'b00010, "bounce_9");
        at_neg_after(181);
        btn = 1'b1;
        at_neg_after(190);
        btn = 1'b0;

        // Press lands on the tick edge at 228: entry shown, tick dropped.
        push(228, 2'd3, 5'b11111, "collide_blink_entry");
        push(232, 2'd3, 5'b00000, "blink_1");
        push(236, 2'd3, 5'b11111, "blink_2");
        push(240, 2'd3, 5'b00000, "blink_3");
        push(244, 2'd3, 5'b11111, "blink_4");
        at_neg_after(221);
        btn = 1'b1;
        at_neg_after(230);
        btn = 1'b0;

        // Wrap back to COUNT.
        push(247, 2'd0, 5'b00000, "press_to_count");
        push(251, 2'd0, 5'b00001, "count_again_1");
        push(255, 2'd0, 5'b00010, "count_again_2");
        at_neg_after(240);
        btn = 1'b1;
        at_neg_after(250);
        btn = 1'b0;

        at_neg_after(258);
        #1 done = 1'b1;
        ->sample_ev;
        #100;
    end

endmodule
